// File: rtl/sm_rom_loader_pkg.sv
// Shared types and constants for the ROM loader.
// The CHECK state only exists when SM_ROM_LOADER_CHECKSUM_EN is defined.
package sm_rom_loader_pkg;

    localparam int BYTES_PER_WORD = 4;

`ifdef SM_ROM_LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        CHECK = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2
    } state_t;
`endif

endpackage

// File: rtl/sm_rom_loader_asm.sv
// Little-endian byte-to-word assembler: a 24-bit shift register for bytes 0..2
// and a 2-bit byte counter; the word is complete when the fourth byte arrives.
module sm_rom_loader_asm
    import sm_rom_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        last
);

    logic [23:0] shift_reg;
    logic [1:0]  cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg <= '0;
            cnt_reg   <= '0;
        end else if (clr) begin
            cnt_reg   <= '0;
        end else if (en) begin
            // Newest byte enters at the top so byte 0 ends up in bits [7:0].
            shift_reg <= {byte_in, shift_reg[23:8]};
            cnt_reg   <= cnt_reg + 2'd1;
        end
    end

    assign word = {byte_in, shift_reg};
    assign last = (cnt_reg == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/sm_rom_loader.sv
// Streams program bytes into instruction memory words and holds the CPU in
// reset until a complete load finishes. Option: SM_ROM_LOADER_CHECKSUM_EN.
module sm_rom_loader
    import sm_rom_loader_pkg::*;
#(
    parameter int SIZE = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_start,
    input  logic [$clog2(SIZE):0]    load_words,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    output logic                     in_ready,
    output logic                     mem_we,
    output logic [31:0]              mem_a,
    output logic [31:0]              mem_wd,
    output logic                     cpu_rst,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int LW = $clog2(SIZE) + 1;

    state_t          state_reg, state_next;
    logic [LW-1:0]   words_reg, idx_reg;
    logic [31:0]     mem_a_reg, mem_wd_reg;
    logic            loaded_reg, err_reg, done_reg;
    logic            start_ok, start_bad, byte_fire, word_fire, last_word;
    logic [31:0]     asm_word;
    logic            asm_last;

    assign start_ok  = (state_reg == IDLE) && load_start &&
                       (load_words != '0) && (load_words <= LW'(SIZE));
    assign start_bad = (state_reg == IDLE) && load_start && !start_ok;
    assign byte_fire = in_valid && in_ready;
    assign word_fire = byte_fire && (state_reg == LOAD) && asm_last;
    assign last_word = (idx_reg == words_reg - 1'b1);

    sm_rom_loader_asm u_asm (
        .clk     (clk),
        .rst     (rst),
        .clr     (start_ok),
        .en      (byte_fire && (state_reg == LOAD)),
        .byte_in (in_data),
        .word    (asm_word),
        .last    (asm_last)
    );

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        mem_we     = 1'b0;
        case (state_reg)
            IDLE:  if (start_ok) state_next = LOAD;
            LOAD: begin
                in_ready = 1'b1;
                if (word_fire) state_next = WRITE;
            end
            WRITE: begin
                mem_we = 1'b1;
`ifdef SM_ROM_LOADER_CHECKSUM_EN
                state_next = last_word ? CHECK : LOAD;
`else
                state_next = last_word ? IDLE : LOAD;
`endif
            end
`ifdef SM_ROM_LOADER_CHECKSUM_EN
            CHECK: begin
                in_ready = 1'b1;
                if (byte_fire) state_next = IDLE;
            end
`endif
            default: state_next = IDLE;
        endcase
    end

`ifdef SM_ROM_LOADER_CHECKSUM_EN
    logic [7:0] csum_reg;

    always_ff @(posedge clk) begin
        if (rst || start_ok)
            csum_reg <= '0;
        else if (byte_fire && (state_reg == LOAD))
            csum_reg <= csum_reg ^ in_data;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            words_reg  <= '0;
            idx_reg    <= '0;
            mem_a_reg  <= '0;
            mem_wd_reg <= '0;
            loaded_reg <= 1'b0;
            err_reg    <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            // loaded follows the done pulse, so cpu_rst drops the cycle after done.
            if (start_ok) begin
                words_reg  <= load_words;
                idx_reg    <= '0;
                err_reg    <= 1'b0;
                loaded_reg <= 1'b0;
            end else if (done_reg) begin
                loaded_reg <= 1'b1;
            end
            if (start_bad) err_reg <= 1'b1;
            if (word_fire) begin
                mem_a_reg  <= 32'(idx_reg) << 2;
                mem_wd_reg <= asm_word;
            end
            if (state_reg == WRITE) begin
                idx_reg <= idx_reg + 1'b1;
`ifndef SM_ROM_LOADER_CHECKSUM_EN
                if (last_word) done_reg <= 1'b1;
`endif
            end
`ifdef SM_ROM_LOADER_CHECKSUM_EN
            if ((state_reg == CHECK) && byte_fire) begin
                if (in_data == csum_reg) done_reg <= 1'b1;
                else                     err_reg  <= 1'b1;
            end
`endif
        end
    end

    assign mem_a   = mem_a_reg;
    assign mem_wd  = mem_wd_reg;
    assign busy    = (state_reg != IDLE);
    assign done    = done_reg;
    assign err     = err_reg;
    assign cpu_rst = busy || !loaded_reg;

endmodule

// File: tb/tb_sm_rom_loader.sv
// Scoreboard bench for sm_rom_loader: the driver pushes expected memory writes,
// a negedge monitor pops and compares them against the DUT write port.
module tb_sm_rom_loader;

    localparam int SIZE = 64;
    localparam int LW   = $clog2(SIZE) + 1;

    logic          clk, rst, load_start, in_valid;
    logic [LW-1:0] load_words;
    logic [7:0]    in_data;
    logic          in_ready, mem_we, cpu_rst, busy, done, err;
    logic [31:0]   mem_a, mem_wd;

    sm_rom_loader #(.SIZE(SIZE)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .load_words (load_words),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .cpu_rst    (cpu_rst),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] wd;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] prog [0:SIZE*4-1];
    int         checks = 0;
    int         errors = 0;
    int         done_cnt = 0;
    bit         chk_rst_next = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h", nm, act, req);
        end
    endtask

    // Monitor: every write must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && mem_we) begin
            $display("write a=%08h wd=%08h", mem_a, mem_wd);
            check("wr_in_ready", 32'(in_ready), 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual a=%08h wd=%08h required=none", mem_a, mem_wd);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", mem_a, e.a);
                check("wr_data", mem_wd, e.wd);
            end
        end
        if (done) begin
            done_cnt++;
            check("cpu_rst_at_done", 32'(cpu_rst), 32'd1);
            chk_rst_next = 1;
        end else if (chk_rst_next) begin
            check("cpu_rst_after_done", 32'(cpu_rst), 32'd0);
            chk_rst_next = 0;
        end
    end

    task automatic fill_random(input int nbytes);
        for (int k = 0; k < nbytes; k++) prog[k] = 8'($urandom_range(0, 255));
    endtask

    task automatic pulse_start(input int lw);
        @(posedge clk); #1;
        load_start = 1'b1;
        load_words = LW'(lw);
        @(posedge clk); #1;
        load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int t;
        if (gap) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready && t < 100);
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL byte_accept_timeout actual=no_ready required=ready");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Model: word w is bytes 4w..4w+3 little-endian, written to byte address 4w.
    task automatic do_load(input int lw, input int nsend, input bit gaps,
                           input bit mid_start, input bit bad_csum);
        logic [7:0] csum;
        csum = 8'h00;
        for (int k = 0; k < 4 * lw; k++) csum = csum ^ prog[k];
        for (int w = 0; w < nsend / 4; w++) begin
            wr_t e;
            e.a  = 32'(w * 4);
            e.wd = 32'(prog[4*w]) + 32'(prog[4*w+1]) * 256 +
                   32'(prog[4*w+2]) * 65536 + 32'(prog[4*w+3]) * 16777216;
            exp_q.push_back(e);
        end
        pulse_start(lw);
        for (int k = 0; k < nsend; k++) begin
            if (mid_start && k == 2) begin
                load_start = 1'b1;
                load_words = LW'(1);
                @(posedge clk); #1;
                load_start = 1'b0;
            end
            send_byte(prog[k], gaps);
        end
`ifdef SM_ROM_LOADER_CHECKSUM_EN
        if (nsend == 4 * lw) send_byte(bad_csum ? csum + 8'd1 : csum, gaps);
`else
        if (bad_csum) $display("note: checksum option not built");
`endif
    endtask

    task automatic wait_idle(input string nm);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (busy && t < 2000);
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL %s_idle_timeout actual=busy required=idle", nm);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic run_good(input string nm, input int lw, input bit gaps, input bit mid_start);
        int base;
        base = done_cnt;
        do_load(lw, 4 * lw, gaps, mid_start, 1'b0);
        wait_idle(nm);
        $display("load %s words=%0d done_pulses=%0d", nm, lw, done_cnt - base);
        check({nm, "_done_pulses"}, 32'(done_cnt - base), 32'd1);
        check({nm, "_queue_left"}, 32'(exp_q.size()), 32'd0);
        check({nm, "_err"}, 32'(err), 32'd0);
        check({nm, "_cpu_rst"}, 32'(cpu_rst), 32'd0);
    endtask

    task automatic run_bad_len(input string nm, input int lw);
        pulse_start(lw);
        repeat (3) begin
            @(negedge clk);
            check({nm, "_busy"}, 32'(busy), 32'd0);
        end
        $display("start %s words=%0d err=%0b", nm, lw, err);
        check({nm, "_err"}, 32'(err), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; load_start = 1'b0; load_words = '0; in_valid = 1'b0; in_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_mem_a", mem_a, 32'd0);
        check("rst_mem_wd", mem_wd, 32'd0);
        check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Two-instruction program from the reference example.
        prog[0] = 8'h13; prog[1] = 8'h00; prog[2] = 8'h50; prog[3] = 8'h00;
        prog[4] = 8'h93; prog[5] = 8'h00; prog[6] = 8'h10; prog[7] = 8'h00;
        run_good("basic", 2, 1'b0, 1'b0);

        run_bad_len("zero_len", 0);
        fill_random(4);
        run_good("clear_err", 1, 1'b0, 1'b0);
        run_bad_len("over_len", SIZE + 1);

        fill_random(12);
        run_good("gaps_midstart", 3, 1'b1, 1'b1);

        for (int r = 0; r < 4; r++) begin
            int lw;
            lw = $urandom_range(1, 6);
            fill_random(4 * lw);
            run_good("random", lw, 1'($urandom_range(0, 1)), 1'b0);
        end

        // Reset after 5 of 8 bytes: only word 0 may have been written.
        fill_random(8);
        do_load(2, 5, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("midrst_busy", 32'(busy), 32'd0);
            check("midrst_cpu_rst", 32'(cpu_rst), 32'd1);
        end
        check("midrst_queue_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        fill_random(4);
        run_good("after_rst", 1, 1'b0, 1'b0);

`ifdef SM_ROM_LOADER_CHECKSUM_EN
        begin
            int base;
            prog[0] = 8'h13; prog[1] = 8'h00; prog[2] = 8'h50; prog[3] = 8'h00;
            base = done_cnt;
            do_load(1, 4, 1'b0, 1'b0, 1'b1);
            wait_idle("csum_bad");
            check("csum_bad_err", 32'(err), 32'd1);
            check("csum_bad_done", 32'(done_cnt - base), 32'd0);
            check("csum_bad_cpu_rst", 32'(cpu_rst), 32'd1);
            run_good("csum_good", 1, 1'b0, 1'b0);
        end
`endif

        fill_random(4 * SIZE);
        run_good("full_depth", SIZE, 1'b0, 1'b0);
        check("full_depth_last_a", mem_a, 32'((SIZE - 1) * 4));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
